// File: rtl/instr_regfile_calc_pkg.sv
// Shared types for the self-computing instruction register: opcodes, sweep FSM
// states, default sizes and the error-flag helper used by the calculator.
package instr_register_pkg;

    localparam int DEFAULT_DEPTH    = 32;
    localparam int DEFAULT_OP_WIDTH = 32;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } sweep_state_t;

    // Division-class ops flag an error whenever the divisor is (treated as) zero.
    function automatic logic calc_err(opcode_t op, logic b_zero);
        return ((op == DIV) || (op == MOD)) && b_zero;
    endfunction

endpackage

// File: rtl/instr_regfile_calc_if.sv
// Write/read/clear port bundle of instr_regfile_calc; master = issue side, slave = block.
interface instr_regfile_calc_if
    import instr_register_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int OP_WIDTH = DEFAULT_OP_WIDTH
) ();
    localparam int AW = $clog2(DEPTH);

    logic                       clear;
    logic                       wr_valid;
    logic                       wr_ready;
    logic [AW-1:0]              write_pointer;
    opcode_t                    opcode;
    logic signed [OP_WIDTH-1:0] operand_a;
    logic signed [OP_WIDTH-1:0] operand_b;
    logic                       rd_en;
    logic [AW-1:0]              read_pointer;
    logic                       rd_data_valid;
    opcode_t                    rd_opcode;
    logic signed [OP_WIDTH-1:0] rd_op_a;
    logic signed [OP_WIDTH-1:0] rd_op_b;
    logic signed [2*OP_WIDTH-1:0] rd_result;
    logic                       rd_err;
    logic                       busy;

    modport master (
        output clear, wr_valid, write_pointer, opcode, operand_a, operand_b,
               rd_en, read_pointer,
        input  wr_ready, rd_data_valid, rd_opcode, rd_op_a, rd_op_b,
               rd_result, rd_err, busy
    );

    modport slave (
        input  clear, wr_valid, write_pointer, opcode, operand_a, operand_b,
               rd_en, read_pointer,
        output wr_ready, rd_data_valid, rd_opcode, rd_op_a, rd_op_b,
               rd_result, rd_err, busy
    );
endinterface

// File: rtl/instr_regfile_calc_calc.sv
// Combinational ALU for one instruction; the divider exists only when
// INSTR_REG_DIV_EN is defined, otherwise DIV/MOD report an error.
module instr_calc
    import instr_register_pkg::*;
#(
    parameter int OP_WIDTH = DEFAULT_OP_WIDTH
) (
    input  opcode_t                      opcode,
    input  logic signed [OP_WIDTH-1:0]   a,
    input  logic signed [OP_WIDTH-1:0]   b,
    output logic signed [2*OP_WIDTH-1:0] result,
    output logic                         err
);
    localparam int RW = 2 * OP_WIDTH;

    logic signed [RW-1:0] a_x;
    logic signed [RW-1:0] b_x;
    logic                 b_zero;

    assign a_x    = {{OP_WIDTH{a[OP_WIDTH-1]}}, a};
    assign b_x    = {{OP_WIDTH{b[OP_WIDTH-1]}}, b};
    assign b_zero = (b == '0);

    always_comb begin
        result = '0;
        err    = 1'b0;
        case (opcode)
            ZERO:  result = '0;
            PASSA: result = a_x;
            PASSB: result = b_x;
            ADD:   result = a_x + b_x;
            SUB:   result = a_x - b_x;
            MULT:  result = a_x * b_x;
            DIV, MOD: begin
`ifdef INSTR_REG_DIV_EN
                // SV signed / and % already truncate toward zero / follow the dividend sign.
                if (!b_zero)
                    result = (opcode == DIV) ? (a_x / b_x) : (a_x % b_x);
                err = calc_err(opcode, b_zero);
`else
                err = calc_err(opcode, 1'b1);
`endif
            end
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/instr_regfile_calc.sv
// Instruction register that computes results in a one-stage pipeline, stores them
// and serves forwarded registered reads; cleared by a sweep. DIV/MOD need INSTR_REG_DIV_EN.
module instr_regfile_calc
    import instr_register_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int OP_WIDTH = DEFAULT_OP_WIDTH
) (
    input logic clk,
    input logic reset,
    instr_regfile_calc_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = 2 * OP_WIDTH;

    typedef struct packed {
        opcode_t                    opc;
        logic signed [OP_WIDTH-1:0] a;
        logic signed [OP_WIDTH-1:0] b;
        logic signed [RW-1:0]       result;
        logic                       err;
    } entry_t;

    typedef struct packed {
        logic                       valid;
        logic [AW-1:0]              addr;
        opcode_t                    opc;
        logic signed [OP_WIDTH-1:0] a;
        logic signed [OP_WIDTH-1:0] b;
    } stage_t;

    sweep_state_t         state, state_nxt;
    logic [AW-1:0]        idx, idx_nxt;
    stage_t               s1;
    logic signed [RW-1:0] s1_result;
    logic                 s1_err;
    entry_t               s1_word;
    entry_t               rd_word;
    entry_t               rd_q;
    logic                 rd_vld_q;
    logic                 wr_ready_int;
    logic                 wr_fire;
    logic                 rd_fire;
    entry_t               mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // A clear pulse during an active sweep is ignored on purpose.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            CLEAR: begin
                if (idx == AW'(DEPTH - 1)) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            IDLE: begin
                if (bus.clear) begin
                    state_nxt = CLEAR;
                    idx_nxt   = '0;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    assign wr_ready_int = (state == IDLE) && !bus.clear;
    assign bus.wr_ready = wr_ready_int;
    assign bus.busy     = (state == CLEAR);
    assign wr_fire      = bus.wr_valid && wr_ready_int;
    assign rd_fire      = bus.rd_en && (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
        end else begin
            s1.valid <= wr_fire;
            if (wr_fire) begin
                s1.addr <= bus.write_pointer;
                s1.opc  <= bus.opcode;
                s1.a    <= bus.operand_a;
                s1.b    <= bus.operand_b;
            end
        end
    end

    instr_calc #(.OP_WIDTH(OP_WIDTH)) u_calc (
        .opcode (s1.opc),
        .a      (s1.a),
        .b      (s1.b),
        .result (s1_result),
        .err    (s1_err)
    );

    assign s1_word = '{opc: s1.opc, a: s1.a, b: s1.b, result: s1_result, err: s1_err};

    // Array is left untouched while reset is held; the sweep zeroes it afterwards.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (s1.valid)
                mem[s1.addr] <= s1_word;
            if (state == CLEAR)
                mem[idx] <= '0;
        end
    end

    assign rd_word = (s1.valid && (s1.addr == bus.read_pointer)) ? s1_word
                                                                 : mem[bus.read_pointer];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_q <= 1'b0;
            rd_q     <= '0;
        end else begin
            rd_vld_q <= rd_fire;
            if (rd_fire)
                rd_q <= rd_word;
        end
    end

    assign bus.rd_data_valid = rd_vld_q;
    assign bus.rd_opcode     = rd_q.opc;
    assign bus.rd_op_a       = rd_q.a;
    assign bus.rd_op_b       = rd_q.b;
    assign bus.rd_result     = rd_q.result;
    assign bus.rd_err        = rd_q.err;
endmodule

// File: tb/tb_instr_regfile_calc.sv
// Directed self-checking bench for instr_regfile_calc (DEPTH 32, OP_WIDTH 32).
module tb_instr_regfile_calc;
    import instr_register_pkg::*;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    instr_regfile_calc_if #(.DEPTH(32), .OP_WIDTH(32)) bus ();

    instr_regfile_calc #(.DEPTH(32), .OP_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [159:0] obs, logic [159:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(string tag, logic obs, logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic do_write(logic [4:0] addr, opcode_t op, logic [31:0] a, logic [31:0] b);
        bus.wr_valid      = 1'b1;
        bus.write_pointer = addr;
        bus.opcode        = op;
        bus.operand_a     = a;
        bus.operand_b     = b;
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic read_chk(string tag, logic [4:0] addr, opcode_t e_opc, logic [31:0] e_a,
                            logic [31:0] e_b, logic [63:0] e_res, logic e_err);
        bus.rd_en        = 1'b1;
        bus.read_pointer = addr;
        tick();
        bus.rd_en = 1'b0;
        chk1({tag, " vld"}, bus.rd_data_valid, 1'b1);
        chk({tag, " res"}, 160'({bus.rd_result}), 160'(e_res));
        chk({tag, " fields"}, 160'({bus.rd_opcode, bus.rd_err, bus.rd_op_a, bus.rd_op_b}),
            160'({e_opc, e_err, e_a, e_b}));
    endtask

    // Entered in sweep cycle 0; leaves in cycle 32 (first IDLE cycle).
    task automatic sweep_chk(string tag, int pulse_at);
        bus.rd_en         = 1'b1;
        bus.read_pointer  = 5'd7;
        bus.wr_valid      = 1'b1;
        bus.write_pointer = 5'd30;
        bus.opcode        = PASSA;
        bus.operand_a     = 32'd99;
        for (int k = 0; k < 32; k++) begin
            #1;
            chk1({tag, " busy"}, bus.busy, 1'b1);
            chk1({tag, " wr_ready"}, bus.wr_ready, 1'b0);
            chk1({tag, " rd dropped"}, bus.rd_data_valid, 1'b0);
            bus.clear = (k == pulse_at);
            if (k == 31) begin
                bus.rd_en    = 1'b0;
                bus.wr_valid = 1'b0;
            end
            tick();
        end
        chk1({tag, " end busy"}, bus.busy, 1'b0);
        chk1({tag, " end wr_ready"}, bus.wr_ready, 1'b1);
        chk1({tag, " end rd_vld"}, bus.rd_data_valid, 1'b0);
    endtask

    initial begin
        vectors           = 0;
        miscompares       = 0;
        reset             = 1'b1;
        bus.clear         = 1'b0;
        bus.wr_valid      = 1'b0;
        bus.write_pointer = '0;
        bus.opcode        = ZERO;
        bus.operand_a     = '0;
        bus.operand_b     = '0;
        bus.rd_en         = 1'b0;
        bus.read_pointer  = '0;

        tick();
        chk1("rst busy", bus.busy, 1'b1);
        chk1("rst wr_ready", bus.wr_ready, 1'b0);
        chk1("rst rd_vld", bus.rd_data_valid, 1'b0);
        chk("rst res", 160'({bus.rd_result}), 160'd0);
        tick();
        reset = 1'b0;
        sweep_chk("init", -1);

        read_chk("zero 0", 5'd0, ZERO, 32'd0, 32'd0, 64'd0, 1'b0);
        read_chk("zero 17", 5'd17, ZERO, 32'd0, 32'd0, 64'd0, 1'b0);
        read_chk("zero 31", 5'd31, ZERO, 32'd0, 32'd0, 64'd0, 1'b0);
        read_chk("no wr in clr", 5'd30, ZERO, 32'd0, 32'd0, 64'd0, 1'b0);

        do_write(5'd3, ADD, 32'hFFFF_FFF9, 32'd20);
        read_chk("add fwd", 5'd3, ADD, 32'hFFFF_FFF9, 32'd20, 64'd13, 1'b0);
        read_chk("add arr", 5'd3, ADD, 32'hFFFF_FFF9, 32'd20, 64'd13, 1'b0);
        tick();
        chk1("hold vld", bus.rd_data_valid, 1'b0);
        chk("hold res", 160'({bus.rd_result}), 160'd13);

        do_write(5'd0, MULT, 32'h7FFF_FFFF, 32'd2);
        do_write(5'd1, DIV, 32'hFFFF_FFF9, 32'd2);
        do_write(5'd2, MOD, 32'hFFFF_FFF9, 32'd2);
        do_write(5'd4, DIV, 32'd5, 32'd0);
        do_write(5'd6, DIV, 32'd8, 32'd2);
        do_write(5'd7, SUB, 32'd5, 32'd12);
        do_write(5'd8, PASSB, 32'd0, 32'hFFFF_FFFF);
        read_chk("passb fwd", 5'd8, PASSB, 32'd0, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        read_chk("mult", 5'd0, MULT, 32'h7FFF_FFFF, 32'd2, 64'h0000_0000_FFFF_FFFE, 1'b0);
        read_chk("sub", 5'd7, SUB, 32'd5, 32'd12, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0);
        read_chk("div0", 5'd4, DIV, 32'd5, 32'd0, 64'd0, 1'b1);
`ifdef INSTR_REG_DIV_EN
        read_chk("div neg", 5'd1, DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        read_chk("mod neg", 5'd2, MOD, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        read_chk("div 8/2", 5'd6, DIV, 32'd8, 32'd2, 64'd4, 1'b0);
`else
        read_chk("div neg", 5'd1, DIV, 32'hFFFF_FFF9, 32'd2, 64'd0, 1'b1);
        read_chk("mod neg", 5'd2, MOD, 32'hFFFF_FFF9, 32'd2, 64'd0, 1'b1);
        read_chk("div 8/2", 5'd6, DIV, 32'd8, 32'd2, 64'd0, 1'b1);
`endif

        // Write and read of addr 5 in one cycle: the read sees the old contents.
        bus.wr_valid      = 1'b1;
        bus.write_pointer = 5'd5;
        bus.opcode        = PASSA;
        bus.operand_a     = 32'd9;
        bus.operand_b     = 32'd0;
        bus.rd_en         = 1'b1;
        bus.read_pointer  = 5'd5;
        tick();
        bus.wr_valid = 1'b0;
        bus.rd_en    = 1'b0;
        chk1("same cyc vld", bus.rd_data_valid, 1'b1);
        chk("same cyc res", 160'({bus.rd_result}), 160'd0);
        chk("same cyc opc", 160'({bus.rd_opcode}), 160'd0);
        read_chk("next cyc", 5'd5, PASSA, 32'd9, 32'd0, 64'd9, 1'b0);
        do_write(5'd5, PASSA, 32'd9, 32'd0);
        do_write(5'd5, PASSA, 32'd11, 32'd0);
        read_chk("b2b fwd", 5'd5, PASSA, 32'd11, 32'd0, 64'd11, 1'b0);
        read_chk("b2b arr", 5'd5, PASSA, 32'd11, 32'd0, 64'd11, 1'b0);

        for (int i = 0; i < 10; i++)
            do_write(5'(10 + i), ADD, 32'(i), 32'(i));
        bus.clear = 1'b1;
        #1;
        chk1("clear wr_ready", bus.wr_ready, 1'b0);
        tick();
        bus.clear = 1'b0;
        sweep_chk("clr", 10);
        read_chk("clr 10", 5'd10, ZERO, 32'd0, 32'd0, 64'd0, 1'b0);
        read_chk("clr 19", 5'd19, ZERO, 32'd0, 32'd0, 64'd0, 1'b0);
        read_chk("clr 3", 5'd3, ZERO, 32'd0, 32'd0, 64'd0, 1'b0);

        do_write(5'd25, PASSA, 32'd55, 32'd0);
        read_chk("pre rst", 5'd25, PASSA, 32'd55, 32'd0, 64'd55, 1'b0);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        repeat (12) tick();
        reset = 1'b1;
        tick();
        chk1("rst2 busy", bus.busy, 1'b1);
        chk1("rst2 wr_ready", bus.wr_ready, 1'b0);
        chk1("rst2 rd_vld", bus.rd_data_valid, 1'b0);
        chk("rst2 res", 160'({bus.rd_result}), 160'd0);
        chk("rst2 op_a", 160'({bus.rd_op_a}), 160'd0);
        reset = 1'b0;
        sweep_chk("rst2", -1);
        read_chk("rst2 25", 5'd25, ZERO, 32'd0, 32'd0, 64'd0, 1'b0);

        do_write(5'd31, ADD, 32'd1, 32'd2);
        tick();
        read_chk("last addr", 5'd31, ADD, 32'd1, 32'd2, 64'd3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instr_regfile_calc.md
# instr_regfile_calc

Parametrised, self-computing successor of the instruction register. Accepts instruction writes (opcode plus two signed operands) through a valid/ready port and computes the result in a one-stage pipeline. Stores opcode, operands, result and an error flag per entry, and serves registered reads with forwarding. It sits between the instruction-issue logic and the result consumers, and is cleared by a sequential sweep rather than a one-cycle array reset.

## Interface
- DEPTH, 32: number of entries; power of two, ≥ 4.
- OP_WIDTH, 32: signed operand width.
- AW, $clog2(DEPTH): pointer width (derived, not overridden).
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  one-cycle pulse; starts a clear sweep.
- wr_valid  in  1  write request.
- wr_ready  out  1  block can accept a write this cycle.
- write_pointer  in  AW  write address.
- opcode  in  opcode_t  operation.
- operand_a  in  OP_WIDTH  signed operand A.
- operand_b  in  OP_WIDTH  signed operand B.
- rd_en  in  1  read request.
- read_pointer  in  AW  read address.
- rd_data_valid  out  1  read data present this cycle.
- rd_opcode  out  opcode_t  stored opcode.
- rd_op_a  out  OP_WIDTH  stored operand A.
- rd_op_b  out  OP_WIDTH  stored operand B.
- rd_result  out  2*OP_WIDTH  stored signed result.
- rd_err  out  1  stored error flag.
- busy  out  1  clear sweep in progress.

## Operation
- FSM states are CLEAR and IDLE.
  - reset forces CLEAR with index 0.
  - CLEAR zeroes entry[index] each cycle. At index == DEPTH-1 the FSM goes to IDLE.
  - In IDLE, clear==1 goes to CLEAR with index 0.
- wr_ready = (state == IDLE) && !clear. busy = (state == CLEAR).
- A write is accepted when wr_valid && wr_ready. It is captured into stage register s1 (valid, addr, opc, a, b).
- The result is computed combinationally from s1. Entry[s1.addr] is written at the next edge.
- Arithmetic: operands are sign-extended to 2*OP_WIDTH.
  - ZERO → 0; PASSA → a; PASSB → b; ADD → a+b; SUB → a−b; MULT → full signed product.
  - DIV truncates toward zero. MOD takes the sign of the dividend.
  - Divide by zero: result 0 and err = 1. All other cases: err = 0.
- Reads are accepted only in IDLE (rd_en && state == IDLE). Reads in CLEAR are dropped.
- Read forwarding: if s1.valid and s1.addr == read_pointer, the read returns s1's computed word instead of the array entry.
- Unwritten or cleared entries read as all zeros (opcode ZERO, err 0).

## Timing
- During reset and for the cycle after it, all outputs are 0 except busy = 1. s1.valid is 0 and the array is untouched until the sweep runs.
- After reset deasserts, CLEAR lasts exactly DEPTH cycles. wr_ready rises in cycle DEPTH (counting the first cycle with reset low as cycle 0).
- Write latency: a write accepted in cycle t is in the array at the end of cycle t+1. Reads issued in cycle t+1 or later see it, via forwarding in t+1.
- Read latency: rd_en in cycle t gives rd_data_valid = 1 and data in cycle t+1. Outputs hold their last value, with rd_data_valid = 0, when no read occurs.
- Write and read to the same address in the same cycle t: the read returns the old contents.
- Back-to-back writes to the same address: the last one wins. Forwarding always uses the youngest write.
- clear while s1 is valid: the s1 write commits at the same edge, then the sweep erases it.
- reset mid-operation: s1 is dropped, the sweep restarts at index 0, and any pending read is dropped.
- clear asserted while already in CLEAR: ignored; the sweep is not restarted.
- Pointers are unsigned AW bits, so there is no wrap logic.

## Configuration
- INSTR_REG_DIV_EN defined: DIV and MOD are computed as above.
- INSTR_REG_DIV_EN undefined: no divider is synthesised. DIV and MOD store result 0 and err = 1 for any operands.

## Structure
- instr_register_pkg holds:
  - opcode_t (ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD = 0..7);
  - the default parameter constants;
  - a function computing err for a given opcode/operand_b.
- Sub-module instr_calc is purely combinational. Inputs are opcode, a and b; outputs are result and err. It contains the INSTR_REG_DIV_EN guard.
- Top level contains the FSM, sweep counter, s1 register, array, forwarding mux and read register.

## Test plan
- Reset for 2 cycles, then release → busy = 1 for 32 cycles, wr_ready = 1 at cycle 32, and every read returns zeros.
- Write addr 3 with ADD a = −7, b = 20; read addr 3 one cycle later (forwarded) and two cycles later → both give rd_result = 13, err = 0.
- MULT a = 0x7FFFFFFF, b = 2 at addr 0 → rd_result = 0x00000000FFFFFFFE. DIV a = −7, b = 2 → −3. MOD a = −7, b = 2 → −1.
- DIV a = 5, b = 0 → result 0, err = 1. With INSTR_REG_DIV_EN undefined, DIV 8/2 → result 0, err = 1.
- Write addr 5 (PASSA 9) and read addr 5 in the same cycle → old value 0. Next-cycle read → 9. Two consecutive writes to addr 5 (9, then 11), then read → 11.
- Write 10 entries, pulse clear in the cycle after the last write → busy for 32 cycles, wr_ready = 0, reads dropped. Afterwards all entries read zero. Reset asserted at sweep index 12 → the sweep restarts and takes a full 32 cycles.
